acc_fp_issue_ctrl: RTL and testbench

//  Issue controller between the FP offload predecoder and the FP accelerator on the CV-X-IF path.

---
 rtl/acc_fp_issue_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_acc_fp_issue_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_fp_issue_ctrl.sv
// FP offload issue controller on the CV-X-IF path: registers requests,
// assigns IDs, tracks integer-rd hazards and serialises FP CSR instrs.
module acc_fp_issue_ctrl #(
    parameter int MaxOutstanding = 4,
    parameter int IdWidth        = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [31:0]        req_instr_i,
    input  logic [31:0]        req_rs1_i,
    input  logic               req_use_rs1_i,
    input  logic               req_wb_i,
    output logic               acc_valid_o,
    input  logic               acc_ready_i,
    output logic [31:0]        acc_instr_o,
    output logic [31:0]        acc_rs1_o,
    output logic [IdWidth-1:0] acc_id_o,
    input  logic               rsp_valid_i,
    input  logic [IdWidth-1:0] rsp_id_i,
    output logic [IdWidth:0]   outstanding_o,
    output logic               busy_o
);

    localparam int NumSlots = 2 ** IdWidth;
    localparam logic [IdWidth:0] MaxOut = (IdWidth + 1)'(MaxOutstanding);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StCsr   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic               acc_valid_q;
    logic [31:0]        instr_q;
    logic [31:0]        rs1_q;
    logic [IdWidth-1:0] id_q;

    logic [NumSlots-1:0] slot_valid_q, slot_valid_d;
    logic [NumSlots-1:0] slot_wb_q;
    logic [4:0]          slot_rd_q [NumSlots];
    logic [31:0]         pend_q, pend_d;
    logic [IdWidth-1:0]  next_id_q;
    logic [IdWidth-1:0]  csr_id_q;
    logic [IdWidth:0]    outst_q, outst_d;

    logic [4:0] req_rd;
    logic [4:0] req_rs1;
    logic       req_is_csr;
    logic       hazard_ok;
    logic       issue_free;
    logic       rsp_hit;
    logic       can_accept;
    logic       req_fire;

    assign req_rd     = req_instr_i[11:7];
    assign req_rs1    = req_instr_i[19:15];
    assign req_is_csr = (req_instr_i[6:0] == 7'b1110011);
    assign issue_free = !acc_valid_q || acc_ready_i;
    assign rsp_hit    = rsp_valid_i && slot_valid_q[rsp_id_i];

    // Every accept condition looks only at registered tracking state.
    assign hazard_ok = (outst_q < MaxOut)
                    && !slot_valid_q[next_id_q]
                    && !(req_use_rs1_i && pend_q[req_rs1])
                    && !(req_wb_i && pend_q[req_rd]);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (req_valid_i && req_is_csr) begin
                    if (outst_q != '0) begin
                        state_d = StDrain;
                    end else if (req_fire) begin
                        state_d = StCsr;
                    end
                end
            end
            StDrain: begin
                if (!req_valid_i || !req_is_csr) begin
                    state_d = StRun;
                end else if (req_fire) begin
                    state_d = StCsr;
                end
            end
            StCsr: begin
                if (rsp_hit && (rsp_id_i == csr_id_q)) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        can_accept = 1'b0;
        unique case (state_q)
            StRun:   can_accept = hazard_ok && (!req_is_csr || (outst_q == '0));
            StDrain: can_accept = hazard_ok && req_is_csr && (outst_q == '0);
            StCsr:   can_accept = 1'b0;
            default: can_accept = 1'b0;
        endcase
    end

    assign req_ready_o = rst_ni && issue_free && can_accept;
    assign req_fire    = req_valid_i && req_ready_o;

    // Release is applied before allocate; the two never touch the same entry.
    always_comb begin
        slot_valid_d = slot_valid_q;
        pend_d       = pend_q;
        outst_d      = outst_q;
        if (rsp_hit) begin
            slot_valid_d[rsp_id_i] = 1'b0;
            if (slot_wb_q[rsp_id_i]) begin
                pend_d[slot_rd_q[rsp_id_i]] = 1'b0;
            end
        end
        if (req_fire) begin
            slot_valid_d[next_id_q] = 1'b1;
            if (req_wb_i && (req_rd != 5'd0)) begin
                pend_d[req_rd] = 1'b1;
            end
        end
        if (req_fire && !rsp_hit) begin
            outst_d = outst_q + (IdWidth + 1)'(1);
        end else if (!req_fire && rsp_hit) begin
            outst_d = outst_q - (IdWidth + 1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_valid_q  <= 1'b0;
            instr_q      <= '0;
            rs1_q        <= '0;
            id_q         <= '0;
            slot_valid_q <= '0;
            slot_wb_q    <= '0;
            pend_q       <= '0;
            next_id_q    <= '0;
            csr_id_q     <= '0;
            outst_q      <= '0;
            for (int i = 0; i < NumSlots; i++) begin
                slot_rd_q[i] <= '0;
            end
        end else begin
            slot_valid_q <= slot_valid_d;
            pend_q       <= pend_d;
            outst_q      <= outst_d;
            if (req_fire) begin
                acc_valid_q          <= 1'b1;
                instr_q              <= req_instr_i;
                rs1_q                <= req_rs1_i;
                id_q                 <= next_id_q;
                slot_rd_q[next_id_q] <= req_rd;
                slot_wb_q[next_id_q] <= req_wb_i;
                next_id_q            <= next_id_q + IdWidth'(1);
                if (req_is_csr) begin
                    csr_id_q <= next_id_q;
                end
            end else if (acc_ready_i) begin
                acc_valid_q <= 1'b0;
            end
        end
    end

    assign acc_valid_o   = acc_valid_q;
    assign acc_instr_o   = instr_q;
    assign acc_rs1_o     = rs1_q;
    assign acc_id_o      = id_q;
    assign outstanding_o = outst_q;
    assign busy_o        = (outst_q != '0) || (state_q != StRun);

endmodule

// File: tb/tb_acc_fp_issue_ctrl.sv
// Randomised bench for acc_fp_issue_ctrl: reference model predicts
// handshakes and counts; a scoreboard checks issued instr/rs1/id.
module tb_acc_fp_issue_ctrl;

    logic        clk_i;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_instr_i;
    logic [31:0] req_rs1_i;
    logic        req_use_rs1_i;
    logic        req_wb_i;
    logic        acc_valid_o;
    logic        acc_ready_i;
    logic [31:0] acc_instr_o;
    logic [31:0] acc_rs1_o;
    logic [1:0]  acc_id_o;
    logic        rsp_valid_i;
    logic [1:0]  rsp_id_i;
    logic [2:0]  outstanding_o;
    logic        busy_o;

    acc_fp_issue_ctrl #(
        .MaxOutstanding(4),
        .IdWidth(2)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_instr_i(req_instr_i),
        .req_rs1_i(req_rs1_i),
        .req_use_rs1_i(req_use_rs1_i),
        .req_wb_i(req_wb_i),
        .acc_valid_o(acc_valid_o),
        .acc_ready_i(acc_ready_i),
        .acc_instr_o(acc_instr_o),
        .acc_rs1_o(acc_rs1_o),
        .acc_id_o(acc_id_o),
        .rsp_valid_i(rsp_valid_i),
        .rsp_id_i(rsp_id_i),
        .outstanding_o(outstanding_o),
        .busy_o(busy_o)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [1:0]  id;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   pops = 0;
    int   csr_accepts = 0;

    // Reference model: the set of in-flight transactions by ID.
    bit m_init = 0;
    int m_mode = 0;
    int m_next = 0;
    int m_csr  = 0;
    bit m_hold = 0;
    bit m_val [4];
    int m_rd  [4];
    bit m_wb  [4];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int inflight();
        int n = 0;
        for (int i = 0; i < 4; i++) if (m_val[i]) n++;
        return n;
    endfunction

    function automatic bit pending(input int r);
        if (r == 0) return 1'b0;
        for (int i = 0; i < 4; i++)
            if (m_val[i] && m_wb[i] && m_rd[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_ready();
        int cnt;
        bit is_csr, ok, r;
        if (!rst_ni) return 1'b0;
        cnt    = inflight();
        is_csr = (req_instr_i[6:0] == 7'h73);
        ok = (cnt < 4) && !m_val[m_next]
          && !(req_use_rs1_i && pending(int'(req_instr_i[19:15])))
          && !(req_wb_i && pending(int'(req_instr_i[11:7])));
        case (m_mode)
            0:       r = ok && (!is_csr || cnt == 0);
            1:       r = ok && is_csr && cnt == 0;
            default: r = 1'b0;
        endcase
        return r && (!m_hold || acc_ready_i);
    endfunction

    always @(negedge clk_i) begin
        bit rdy, fire, hit, is_csr;
        int cnt;
        rdy = model_ready();
        cnt = inflight();
        if (m_init) begin
            check("req_ready", 32'(req_ready_o), 32'(rdy));
            check("acc_valid", 32'(acc_valid_o), 32'(m_hold));
            check("outstanding", 32'(outstanding_o), 32'(cnt));
            check("busy", 32'(busy_o), 32'(cnt != 0 || m_mode != 0));
        end
        if (!rst_ni) begin
            m_init = 1;
            m_mode = 0;
            m_next = 0;
            m_csr  = 0;
            m_hold = 0;
            for (int i = 0; i < 4; i++) begin
                m_val[i] = 0;
                m_rd[i]  = 0;
                m_wb[i]  = 0;
            end
            exp_q.delete();
        end else if (m_init) begin
            is_csr = (req_instr_i[6:0] == 7'h73);
            fire   = req_valid_i && rdy;
            hit    = rsp_valid_i && m_val[rsp_id_i];
            case (m_mode)
                0: if (req_valid_i && is_csr) begin
                    if (cnt != 0) m_mode = 1;
                    else if (fire) m_mode = 2;
                end
                1: if (!req_valid_i || !is_csr) m_mode = 0;
                   else if (fire) m_mode = 2;
                default: if (hit && int'(rsp_id_i) == m_csr) m_mode = 0;
            endcase
            if (hit) m_val[rsp_id_i] = 0;
            if (fire) begin
                m_val[m_next] = 1;
                m_rd[m_next]  = int'(req_instr_i[11:7]);
                m_wb[m_next]  = req_wb_i;
                exp_q.push_back('{req_instr_i, req_rs1_i, 2'(m_next)});
                if (is_csr) begin
                    m_csr = m_next;
                    csr_accepts++;
                end
                m_next = (m_next + 1) % 4;
                m_hold = 1;
            end else if (acc_ready_i) begin
                m_hold = 0;
            end
        end
    end

    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni && m_init && acc_valid_o === 1'b1 && acc_ready_i) begin
            if (exp_q.size() == 0) begin
                check("acc_unexpected", 32'(acc_valid_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                pops++;
                check("acc_instr", acc_instr_o, e.instr);
                check("acc_rs1", acc_rs1_o, e.rs1);
                check("acc_id", 32'(acc_id_o), 32'(e.id));
            end
        end
    end

    task automatic gen_req();
        int kind;
        logic [4:0] rd, rs;
        kind = int'($urandom_range(0, 7));
        rd   = 5'($urandom_range(0, 3));
        rs   = 5'($urandom_range(0, 3));
        req_valid_i = ($urandom_range(0, 3) != 0);
        req_rs1_i   = $urandom;
        if (kind == 7) begin
            req_instr_i   = {12'h003, 5'd0, 3'b010, rd, 7'b1110011};
            req_use_rs1_i = 1'b0;
            req_wb_i      = (rd != 5'd0);
        end else if (kind % 3 == 0) begin
            req_instr_i   = {7'b0000000, 5'd2, rs, 3'b000, rd, 7'b1010011};
            req_use_rs1_i = 1'b0;
            req_wb_i      = 1'b0;
        end else if (kind % 3 == 1) begin
            req_instr_i   = {7'b1100000, 5'd0, rs, 3'b000, rd, 7'b1010011};
            req_use_rs1_i = 1'b0;
            req_wb_i      = 1'b1;
        end else begin
            req_instr_i   = {7'b1101000, 5'd0, rs, 3'b000, rd, 7'b1010011};
            req_use_rs1_i = 1'b1;
            req_wb_i      = 1'b0;
        end
    endtask

    initial begin
        bit fired;
        rst_ni        = 1'b0;
        req_valid_i   = 1'b0;
        req_instr_i   = '0;
        req_rs1_i     = '0;
        req_use_rs1_i = 1'b0;
        req_wb_i      = 1'b0;
        acc_ready_i   = 1'b0;
        rsp_valid_i   = 1'b0;
        rsp_id_i      = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_i);
            fired = req_valid_i && req_ready_o;
            @(posedge clk_i);
            #1;
            rst_ni = ($urandom_range(0, 299) != 0);
            if (fired || !req_valid_i || $urandom_range(0, 15) == 0) gen_req();
            acc_ready_i = ($urandom_range(0, 3) != 0);
            rsp_valid_i = ($urandom_range(0, 2) == 0);
            rsp_id_i    = 2'($urandom_range(0, 3));
        end
        @(posedge clk_i);
        #1;
        rst_ni      = 1'b1;
        req_valid_i = 1'b0;
        rsp_valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        check("acc_activity", 32'(pops > 100), 32'd1);
        check("csr_activity", 32'(csr_accepts > 0), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
